// File: rtl/instr_sequencer.sv
// Instruction issue FIFO + step counter feeding the control unit's instruction/current_state/clear_counter port.
// Latency: a word pushed at edge t can issue at edge t+1; each instruction occupies 5 cycles with a registered control unit.
// Backpressure: in_ready drops when the FIFO holds DEPTH words or while resetn is low; run=0 only blocks new issues.
module instr_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [15:0]       in_instruction,
    output logic              in_ready,
    input  logic              run,
    input  logic              clear_counter,
    output logic [15:0]       instruction,
    output logic [1:0]        current_state,
    output logic              busy,
    output logic              retired,
    output logic              illegal_op,
    output logic [ADDR_W:0]   fifo_count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        EXEC
    } state_e;

    state_e              state_q;
    logic [15:0]         instr_q;
    logic [1:0]          step_q;
    logic                busy_q;
    logic                retired_q;
    logic                illegal_q;

    logic [15:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [ADDR_W:0]     count_q;

    logic                push;
    logic                pop;
    logic                issue_slot;
    logic                head_legal;
    logic [15:0]         head;

    always_comb begin
        in_ready   = resetn & (count_q != FULL_CNT);
        push       = in_valid & in_ready;
        head       = mem_q[rd_ptr_q];
        // Opcodes 011 and 110 have no datapath in the control unit.
        head_legal = (head[15:13] != 3'b011) && (head[15:13] != 3'b110);
        // A new word may leave the FIFO from IDLE, or on the edge that retires the current one.
        issue_slot = (state_q == IDLE) || ((step_q == 2'b11) && clear_counter);
        pop        = run && (count_q != '0) && issue_slot;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instruction;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            instr_q   <= 16'h0000;
            step_q    <= 2'b00;
            busy_q    <= 1'b0;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    step_q <= 2'b00;
                    busy_q <= 1'b0;
                    if (pop) begin
                        if (head_legal) begin
                            instr_q <= head;
                            busy_q  <= 1'b1;
                            state_q <= EXEC;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (step_q != 2'b11) begin
                        step_q <= step_q + 2'd1;
                    end else if (clear_counter) begin
                        retired_q <= 1'b1;
                        step_q    <= 2'b00;
                        if (pop && head_legal) begin
                            instr_q <= head;
                        end else begin
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                            illegal_q <= pop;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instruction   = instr_q;
    assign current_state = step_q;
    assign busy          = busy_q;
    assign retired       = retired_q;
    assign illegal_op    = illegal_q;
    assign fifo_count    = count_q;

endmodule
